// File: rtl/arbitro_pkg.sv
// Shared definitions for the two-requester datapath arbiter: state encoding and defaults.
package arbitro_pkg;

    localparam int unsigned DefaultW       = 8;
    localparam int unsigned DefaultTimeout = 32;
    // Wide enough for the largest legal TIMEOUT (255).
    localparam int unsigned CntW           = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick with a registered "last served" pointer.
module rr_arbiter2 (
    input  logic ck,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic upd_id,
    output logic any,
    output logic pick
);

    logic ptr_q;

    // Pointer holds the last served requester; reset favours requester 0.
    always_ff @(posedge ck) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else if (upd) begin
            ptr_q <= upd_id;
        end
    end

    always_comb begin
        any  = req0 | req1;
        pick = (req0 & req1) ? ~ptr_q : req1;
    end

endmodule

// File: rtl/arbitro_datapath.sv
// Serialises evaluation requests from two requesters onto one datapath controller,
// with round-robin arbitration and a completion timeout.
module arbitro_datapath
    import arbitro_pkg::*;
#(
    parameter int unsigned W       = DefaultW,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] res,
    output logic         err,
    output logic         dp_inicio,
    output logic [W-1:0] dp_x,
    input  logic         dp_done,
    input  logic [W-1:0] dp_res,
    output logic         busy
);

    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic            winner_q;
    logic [CntW-1:0] cnt_q;
    logic            any_req, pick;

    rr_arbiter2 u_arb (
        .ck     (ck),
        .rst    (rst),
        .req0   (req0),
        .req1   (req1),
        .upd    (state_q == StResp),
        .upd_id (winner_q),
        .any    (any_req),
        .pick   (pick)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req) state_d = StStart;
            StStart: state_d = StWait;
            StWait:  if (dp_done || cnt_q == CntLast) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        dp_inicio = 1'b0;
        unique case (state_q)
            StStart: begin
                dp_inicio = 1'b1;
                gnt0      = ~winner_q;
                gnt1      = winner_q;
            end
            StResp: begin
                ack0 = ~winner_q;
                ack1 = winner_q;
            end
            default: ;
        endcase
        busy = (state_q != StIdle);
    end

    // Completion is tested before the timeout so a done on the last cycle still succeeds.
    always_ff @(posedge ck) begin
        if (rst) begin
            winner_q <= 1'b0;
            cnt_q    <= '0;
            dp_x     <= '0;
            res      <= '0;
            err      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        winner_q <= pick;
                        dp_x     <= pick ? x1 : x0;
                    end
                end
                StStart: cnt_q <= '0;
                StWait: begin
                    if (dp_done) begin
                        res <= dp_res;
                        err <= 1'b0;
                    end else if (cnt_q == CntLast) begin
                        err <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/arbitro_datapath.md
ARBITRO_DATAPATH -- requirements
Module: arbitro_datapath

Interface
REQ-001 Parameter W, default 8, operand/result width in bits.
REQ-002 Parameter TIMEOUT, default 32, maximum WAIT cycles before abort; legal range 2..255.
REQ-003 ck  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req0, req1  input  1 each  requester N asks for one evaluation; held high until ackN.
REQ-006 x0, x1  input  W each  operand of requester N; stable while reqN high.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse: requester N's operand captured.
REQ-008 ack0, ack1  output  1 each  one-cycle pulse: res/err valid for requester N.
REQ-009 res  output  W  result of the last completed operation.
REQ-010 err  output  1  valid with ackN; 1 = operation aborted by timeout.
REQ-011 dp_inicio  output  1  one-cycle start pulse to the datapath controller.
REQ-012 dp_x  output  W  registered operand driven to the datapath.
REQ-013 dp_done  input  1  datapath completion pulse.
REQ-014 dp_res  input  W  datapath result, valid while dp_done high.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states IDLE, START, WAIT, RESP; all outputs registered or decoded from state only (Moore).
REQ-017 IDLE: no request -> stay; any reqN sampled high -> START, winner's xN latched into dp_x on the same edge.
REQ-018 Arbitration round-robin, 1-bit pointer = last served; both requests -> the requester not last served wins; single request always wins.
REQ-019 START lasts exactly one cycle: gntWinner=1, dp_inicio=1, WAIT timeout counter cleared; -> WAIT.
REQ-020 WAIT: dp_done=1 -> res<=dp_res, err<=0, -> RESP; else counter increments.
REQ-021 WAIT: counter reaches TIMEOUT-1 with dp_done=0 -> err<=1, res unchanged, -> RESP.
REQ-022 dp_done sampled in the same cycle as counter = TIMEOUT-1: completion wins, err=0.
REQ-023 RESP lasts one cycle: ackWinner=1; pointer<=winner; -> IDLE.
REQ-024 Minimum latency: req sampled at edge 0 -> gnt cycle 1 -> ack cycle 3 (dp_done in cycle 2).
REQ-025 dp_done outside WAIT is ignored.
REQ-026 reqN dropped after gnt: operation still completes, ackN still issued.
REQ-027 Losing requester stays pending; served in the next IDLE->START, at most one operation later.
REQ-028 gnt0&gnt1, ack0&ack1, gnt&ack never high together.

Reset
REQ-029 rst=1 at a rising edge: state<=IDLE, pointer<=1 (requester 0 favoured first), counter<=0.
REQ-030 Reset values: gnt0=gnt1=ack0=ack1=0, dp_inicio=0, busy=0, err=0, res=0, dp_x=0.
REQ-031 rst mid-operation aborts without ack; the datapath controller is reset by the same rst.
REQ-032 rst overrides every other input in the same cycle.

Structure
REQ-033 State encoding localparams and default W/TIMEOUT in shared package arbitro_pkg.
REQ-034 Sub-module rr_arbiter2 (combinational 2-way round-robin pick plus registered pointer) is natural; rest flat.

Verification
REQ-035 Single: req0=1, x0=8'h05, dp_done two cycles after dp_inicio with dp_res=8'h2A -> gnt0 once, dp_x=8'h05, ack0 once, res=8'h2A, err=0.
REQ-036 Contention after reset: req0=req1=1 -> serves 0 then 1; repeat with both high -> serves 0 then 1 again (strict alternation).
REQ-037 Timeout: dp_done never asserted, TIMEOUT=32 -> ack at cycle 1+32+1 after gnt, err=1, res unchanged.
REQ-038 Boundary: dp_done exactly at counter=TIMEOUT-1 -> err=0, res=dp_res.
REQ-039 rst in WAIT -> next cycle busy=0, no ack, pointer=1; following req1 alone served normally.
REQ-040 Spurious dp_done in IDLE and req0 dropped after gnt0 -> no state change in IDLE; ack0 still issued.
